// File: rtl/section_min_max_arbiter_pkg.sv
// Shared definitions for the section min/max arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE / FEED / DRAIN)
//   chan_w()    : channel-index width, max(1, $clog2(n))
package section_min_max_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/section_min_max_arbiter_if.sv
// Handshake bundle between the per-channel sample sources, the arbiter and
// the downstream meter logic.
//   i_valid/i_ready/i_value : per-channel sample streams (channel k at [k*width +: width])
//   o_valid/o_ready         : result handshake
//   o_channel               : channel the result belongs to
//   o_min_value/o_max_value : section minimum / maximum
// modport master: the sample sources and result consumer; slave: the arbiter.
interface section_min_max_arbiter_if
    import section_min_max_arbiter_pkg::*;
#(
    parameter int width    = 16,
    parameter int channels = 2
);
    localparam int CW = chan_w(channels);

    logic [channels-1:0]       i_valid;
    logic [channels-1:0]       i_ready;
    logic [channels*width-1:0] i_value;
    logic                      o_valid;
    logic                      o_ready;
    logic [CW-1:0]             o_channel;
    logic [width-1:0]          o_min_value;
    logic [width-1:0]          o_max_value;

    modport master (
        output i_valid, i_value, o_ready,
        input  i_ready, o_valid, o_channel, o_min_value, o_max_value
    );

    modport slave (
        input  i_valid, i_value, o_ready,
        output i_ready, o_valid, o_channel, o_min_value, o_max_value
    );

endinterface

// File: rtl/section_min_max.sv
// Section min/max engine: accumulates the unsigned minimum and maximum of
// sample_count accepted samples, then presents them until taken.
//   clk, reset (async, active-high)
//   i_valid/i_ready/i_value : sample input
//   o_valid/o_ready         : result handshake
//   o_min_value/o_max_value : section result (all ones / zero when empty)
module section_min_max #(
    parameter int width        = 16,
    parameter int sample_count = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_value,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [width-1:0] o_min_value,
    output logic [width-1:0] o_max_value
);
    localparam int CNTW = (sample_count > 1) ? $clog2(sample_count) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(sample_count - 1);

    logic [CNTW-1:0]  r_cnt;
    logic [width-1:0] r_min;
    logic [width-1:0] r_max;
    logic             r_last;
    logic             r_valid;
    logic             w_hs;
    logic [width-1:0] w_min_nxt;
    logic [width-1:0] w_max_nxt;

    // Input is refused from the last accepted sample until the result is taken.
    assign i_ready   = !(r_last || r_valid);
    assign w_hs      = i_valid && i_ready;
    assign w_min_nxt = (i_value < r_min) ? i_value : r_min;
    assign w_max_nxt = (i_value > r_max) ? i_value : r_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_min   <= '1;
            r_max   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            // Stage 1: accumulate; flag the section's final sample.
            if (w_hs) begin
                r_min <= w_min_nxt;
                r_max <= w_max_nxt;
                if (r_cnt == LAST) begin
                    r_cnt  <= '0;
                    r_last <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end
            // Stage 2: publish the result one cycle after the final sample.
            if (r_last) begin
                r_last  <= 1'b0;
                r_valid <= 1'b1;
            end
            // Result taken: restart the section from the empty state.
            if (r_valid && o_ready) begin
                r_valid <= 1'b0;
                r_min   <= '1;
                r_max   <= '0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_min_value = r_min;
    assign o_max_value = r_max;

endmodule

// File: rtl/section_min_max_arbiter.sv
// Round-robin arbiter sharing one section_min_max engine among several
// sample streams. A channel owns the engine for a full section; the result
// is forwarded tagged with that channel's index.
//   clk, reset (async, active-high)
//   bus (slave) : per-channel sample streams in, tagged min/max result out
module section_min_max_arbiter
    import section_min_max_arbiter_pkg::*;
#(
    parameter int width        = 16,
    parameter int sample_count = 16,
    parameter int channels     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    section_min_max_arbiter_if.slave bus
);
    localparam int CW   = chan_w(channels);
    localparam int CNTW = (sample_count > 1) ? $clog2(sample_count) : 1;
    localparam logic [CNTW-1:0] LAST    = CNTW'(sample_count - 1);
    localparam logic [CW-1:0]   RR_INIT = CW'(channels - 1);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [CW-1:0]       r_grant;
    logic [CW-1:0]       r_rr;
    logic [CNTW-1:0]     r_cnt;
    logic [CW-1:0]       w_pick;
    logic [channels-1:0] w_vshift;
    logic [channels-1:0] w_i_ready;
    logic [width-1:0]    w_slice;
    logic [width-1:0]    w_eng_value;
    logic [width-1:0]    w_eng_min;
    logic [width-1:0]    w_eng_max;
    logic                w_gvalid;
    logic                w_eng_valid;
    logic                w_eng_ready;
    logic                w_eng_ovalid;
    logic                w_hs;
    logic                w_grant_load;

    // First requesting channel strictly after ptr, wrapping modulo channels.
    // ptr itself is checked last, so a lone requester is always re-granted.
    function automatic logic [CW-1:0] f_rr_pick(input logic [channels-1:0] req,
                                                input logic [CW-1:0]       ptr);
        logic [CW-1:0]       pick;
        logic                found;
        logic [channels-1:0] sh;
        int                  c;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= channels; k++) begin
            c  = (int'(ptr) + k) % channels;
            sh = req >> c;
            if (!found && sh[0]) begin
                pick  = CW'(c);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_pick   = f_rr_pick(bus.i_valid, r_rr);
    assign w_vshift = bus.i_valid >> r_grant;
    assign w_gvalid = w_vshift[0];
    assign w_slice  = width'(bus.i_value >> (int'(r_grant) * width));

    always_comb begin
        w_next_state = r_state;
        w_i_ready    = '0;
        w_eng_valid  = 1'b0;
        w_eng_value  = '0;
        w_hs         = 1'b0;
        w_grant_load = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.i_valid) begin
                    w_grant_load = 1'b1;
                    w_next_state = ST_FEED;
                end
            end
            ST_FEED: begin
                w_eng_valid = w_gvalid;
                w_eng_value = w_slice;
                w_i_ready   = channels'(w_eng_ready) << r_grant;
                w_hs        = w_gvalid && w_eng_ready;
                if (w_hs && (r_cnt == LAST)) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_eng_ovalid && bus.o_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_rr    <= RR_INIT;
            r_cnt   <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant <= w_pick;
                r_rr    <= w_pick;
            end
            if (w_hs) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNTW'(1);
            end
        end
    end

    section_min_max #(
        .width       (width),
        .sample_count(sample_count)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (w_eng_valid),
        .i_ready    (w_eng_ready),
        .i_value    (w_eng_value),
        .o_valid    (w_eng_ovalid),
        .o_ready    (bus.o_ready),
        .o_min_value(w_eng_min),
        .o_max_value(w_eng_max)
    );

    assign bus.i_ready     = w_i_ready;
    assign bus.o_valid     = w_eng_ovalid;
    assign bus.o_channel   = r_grant;
    assign bus.o_min_value = w_eng_min;
    assign bus.o_max_value = w_eng_max;

endmodule

// File: tb/tb_section_min_max_arbiter.sv
// Scoreboard bench: DUT A (2 channels) runs directed sections with
// back-pressure, stalls and mid-section reset; DUT B (3 channels) runs
// continuous requests to observe rotation and the one-cycle grant bubble.
module tb_section_min_max_arbiter;

    typedef struct {
        int ch;
        int mn;
        int mx;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_tests;
    int   n_fail;

    exp_t        sbA[$];
    exp_t        sbB[$];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          a0_pops;
    int          a0_stop;
    logic        a0_resume;
    logic [1:0]  a_ready_or;
    logic        b_done;

    section_min_max_arbiter_if #(.width(16), .channels(2)) a_if ();
    section_min_max_arbiter_if #(.width(16), .channels(3)) b_if ();

    section_min_max_arbiter #(.width(16), .sample_count(4), .channels(2)) u_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (a_if)
    );

    section_min_max_arbiter #(.width(16), .sample_count(4), .channels(3)) u_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (b_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_p();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int ch, input int mn, input int mx);
        exp_t e;
        e.ch = ch;
        e.mn = mn;
        e.mx = mx;
        sbA.push_back(e);
    endtask

    task automatic wait_sb(input int budget);
        for (int k = 0; k < budget && sbA.size() != 0; k++) @(negedge clk);
        if (sbA.size() != 0) begin
            check("a_result_timeout", 32'(sbA.size()), 0);
            sbA.delete();
        end
        step_p();
    endtask

    // DUT A sample sources: present queue heads, pop on observed handshakes.
    initial begin
        logic [1:0] hs;
        logic [1:0] v;
        a_if.i_valid = '0;
        a_if.i_value = '0;
        forever begin
            @(negedge clk);
            hs = a_if.i_valid & a_if.i_ready;
            @(posedge clk);
            #1;
            if (hs[0] && q0.size() > 0) begin
                void'(q0.pop_front());
                a0_pops++;
            end
            if (hs[1] && q1.size() > 0) void'(q1.pop_front());
            v[0] = (q0.size() > 0) && !((a0_stop >= 0) && (a0_pops >= a0_stop) && !a0_resume);
            v[1] = (q1.size() > 0);
            a_if.i_valid = v;
            a_if.i_value = {(q1.size() > 0) ? q1[0] : 16'd0, (q0.size() > 0) ? q0[0] : 16'd0};
        end
    end

    // DUT A monitor: result scoreboard, hold stability, one-hot ready.
    initial begin
        logic        stall;
        logic [15:0] pmin;
        logic [15:0] pmax;
        logic        pch;
        exp_t        e;
        stall = 1'b0;
        pmin  = '0;
        pmax  = '0;
        pch   = 1'b0;
        forever begin
            @(negedge clk);
            a_ready_or = a_ready_or | a_if.i_ready;
            check("a_ready_onehot", 32'($countones(a_if.i_ready) <= 1), 1);
            if (stall) begin
                check("a_hold_valid", 32'(a_if.o_valid), 1);
                check("a_hold_min", 32'(a_if.o_min_value), 32'(pmin));
                check("a_hold_max", 32'(a_if.o_max_value), 32'(pmax));
                check("a_hold_channel", 32'(a_if.o_channel), 32'(pch));
            end
            stall = !rst_a && a_if.o_valid && !a_if.o_ready;
            pmin  = a_if.o_min_value;
            pmax  = a_if.o_max_value;
            pch   = a_if.o_channel;
            if (!rst_a && a_if.o_valid && a_if.o_ready) begin
                check("a_result_pending", 32'(sbA.size() > 0), 1);
                if (sbA.size() > 0) begin
                    e = sbA.pop_front();
                    check("a_channel", 32'(a_if.o_channel), 32'(e.ch));
                    check("a_min", 32'(a_if.o_min_value), 32'(e.mn));
                    check("a_max", 32'(a_if.o_max_value), 32'(e.mx));
                end
            end
        end
    end

    // DUT B: all three channels request continuously for six sections.
    initial begin
        exp_t e;
        int   nres;
        int   phase;
        int   nextch;
        b_done       = 1'b0;
        rst_b        = 1'b1;
        b_if.i_valid = '0;
        b_if.o_ready = 1'b1;
        b_if.i_value = {16'd102, 16'd101, 16'd100};
        for (int i = 0; i < 6; i++) begin
            e.ch = i % 3;
            e.mn = 100 + (i % 3);
            e.mx = 100 + (i % 3);
            sbB.push_back(e);
        end
        repeat (3) @(negedge clk);
        check("b_rst_channel", 32'(b_if.o_channel), 0);
        rst_b = 1'b0;
        step_p();
        b_if.i_valid = 3'b111;
        nres   = 0;
        phase  = 0;
        nextch = 0;
        for (int cyc = 0; cyc < 400 && nres < 6; cyc++) begin
            @(negedge clk);
            if (phase == 1) begin
                check("b_bubble_ready", 32'(b_if.i_ready), 0);
                phase = 2;
            end else if (phase == 2) begin
                check("b_next_grant", 32'(b_if.i_ready), 32'(3'b001 << nextch));
                phase = 0;
            end
            if (b_if.o_valid && b_if.o_ready) begin
                check("b_result_pending", 32'(sbB.size() > 0), 1);
                if (sbB.size() > 0) begin
                    e = sbB.pop_front();
                    check("b_channel", 32'(b_if.o_channel), 32'(e.ch));
                    check("b_min", 32'(b_if.o_min_value), 32'(e.mn));
                    check("b_max", 32'(b_if.o_max_value), 32'(e.mx));
                    nextch = (e.ch + 1) % 3;
                end
                nres++;
                if (nres < 6) phase = 1;
                else b_if.i_valid = '0;
            end
        end
        check("b_results_seen", 32'(nres), 6);
        b_done = 1'b1;
    end

    // DUT A directed sequence.
    initial begin
        logic seen;
        n_tests      = 0;
        n_fail       = 0;
        a0_pops      = 0;
        a0_stop      = -1;
        a0_resume    = 1'b0;
        a_ready_or   = '0;
        rst_a        = 1'b1;
        a_if.o_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_o_valid", 32'(a_if.o_valid), 0);
        check("rst_o_min", 32'(a_if.o_min_value), 32'hFFFF);
        check("rst_o_max", 32'(a_if.o_max_value), 0);
        check("rst_o_channel", 32'(a_if.o_channel), 0);
        check("rst_i_ready", 32'(a_if.i_ready), 0);
        step_p();
        rst_a = 1'b0;
        step_p();

        // Channel 0 alone.
        a_ready_or = '0;
        q0 = {16'd1, 16'd9, 16'd3, 16'd5};
        push_exp(0, 1, 9);
        wait_sb(60);
        check("t1_ch1_ready_low", 32'(a_ready_or[1]), 0);

        // Both channels, fresh from reset: ch0 first, then ch1, then back to ch0.
        rst_a = 1'b1;
        step_p();
        rst_a = 1'b0;
        step_p();
        q0 = {16'd10, 16'd20, 16'd30, 16'd40};
        q1 = {16'd7, 16'd7, 16'd2, 16'd8};
        push_exp(0, 10, 40);
        push_exp(1, 2, 8);
        wait_sb(100);
        q0 = {16'd11, 16'd12, 16'd13, 16'd14};
        q1 = {16'd5, 16'd6, 16'd7, 16'd8};
        push_exp(0, 11, 14);
        push_exp(1, 5, 8);
        wait_sb(100);

        // Back-pressure on the ch0 result while ch1 is waiting.
        a_if.o_ready = 1'b0;
        q0 = {16'd3, 16'd4, 16'd5, 16'd6};
        q1 = {16'd60, 16'd50, 16'd70, 16'd55};
        push_exp(0, 3, 6);
        push_exp(1, 50, 70);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = a_if.o_valid;
        end
        check("t3_valid_seen", 32'(seen), 1);
        repeat (5) begin
            @(negedge clk);
            check("t3_i_ready_zero", 32'(a_if.i_ready), 0);
        end
        check("t3_ch1_untouched", 32'(q1.size()), 4);
        step_p();
        a_if.o_ready = 1'b1;
        wait_sb(100);

        // Ch0 stalls after two samples; ch1 must wait.
        a0_stop   = a0_pops + 2;
        a0_resume = 1'b0;
        q0 = {16'd21, 16'd22, 16'd23, 16'd24};
        q1 = {16'd31, 16'd32, 16'd33, 16'd34};
        push_exp(0, 21, 24);
        push_exp(1, 31, 34);
        for (int k = 0; k < 40 && a0_pops < a0_stop; k++) step_p();
        check("t4_ch0_held", 32'(a0_pops == a0_stop), 1);
        a_ready_or = '0;
        repeat (6) @(negedge clk);
        check("t4_ch1_stalled", 32'(a_ready_or[1]), 0);
        check("t4_ch0_left", 32'(q0.size()), 2);
        check("t4_ch1_left", 32'(q1.size()), 4);
        step_p();
        a0_resume = 1'b1;
        wait_sb(100);

        // Reset after two samples of a section discards it.
        q0 = {16'd500, 16'd600, 16'd700, 16'd800};
        for (int k = 0; k < 40 && q0.size() > 2; k++) step_p();
        check("t5_two_taken", 32'(q0.size()), 2);
        rst_a = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) begin
            @(negedge clk);
            check("t5_rst_o_valid", 32'(a_if.o_valid), 0);
            check("t5_rst_i_ready", 32'(a_if.i_ready), 0);
        end
        step_p();
        rst_a = 1'b0;
        step_p();
        q0 = {16'd100, 16'd0, 16'd50, 16'd25};
        push_exp(0, 0, 100);
        wait_sb(60);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 1000 && !b_done; k++) @(negedge clk);
        check("b_finished", 32'(b_done), 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/section_min_max_arbiter.md
Name: section_min_max_arbiter

Overview:
- Shares one section_min_max engine among `channels` independent sample streams, e.g. the L/R or multichannel inputs of the level meter.
- Grants the engine to one channel for a whole section of `sample_count` samples, in round-robin order.
- Routes that channel's samples into the engine, then forwards the engine's min/max result downstream, tagged with the channel index.
- Sits between the per-channel sample sources and the meter scaling/display logic.

Parameters:
width, 16, sample bit width (unsigned compare, as in the engine)
sample_count, 16, samples per section; must be >= 1
channels, 2, number of requesting streams; must be >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
i_valid  input  channels  per-channel sample valid
i_ready  output  channels  per-channel ready; at most one bit high
i_value  input  channels*width  packed samples; channel k occupies bits [k*width +: width]
o_valid  output  1  result valid
o_ready  input  1  downstream ready
o_channel  output  max(1,$clog2(channels))  channel index of the current result
o_min_value  output  width  section minimum
o_max_value  output  width  section maximum

Behaviour:
- Reset:
  - Asynchronous, active-high, also applied to the engine.
  - Values after reset: state=IDLE, grant=0, rr pointer=channels-1 (so channel 0 has first priority), sample counter=0, o_channel=0.
  - Engine outputs after reset: o_valid=0, o_min_value=all ones, o_max_value=0.
  - i_ready=all zeros.
- States: IDLE, FEED, DRAIN.
- IDLE:
  - If any i_valid bit is set, grant the first valid channel searching from rr pointer+1 upward, wrapping modulo `channels`.
  - Register the grant index into o_channel and the rr pointer, then go to FEED.
  - No sample is accepted in the IDLE cycle. This one-cycle arbitration bubble is the only overhead per section.
- FEED:
  - i_ready[g] = engine i_ready; all other i_ready bits = 0.
  - Engine i_valid = i_valid[g]; engine i_value = slice g.
  - Each i_valid[g]&&i_ready[g] handshake increments the sample counter.
  - On the `sample_count`-th handshake: counter returns to 0, go to DRAIN.
- DRAIN:
  - All i_ready=0.
  - o_valid, o_min_value and o_max_value are passed straight through from the engine; o_ready is passed to the engine.
  - The engine asserts o_valid 2 cycles after the last accepted sample.
  - On o_valid&&o_ready, go to IDLE. The engine resets its min/max internally at the same time.
- o_channel is stable from grant until the result handshake completes.
- o_valid/o_min_value/o_max_value must not change while o_valid=1 and o_ready=0.
- Boundary conditions:
  - Granted channel drops i_valid mid-section: grant is held and other channels stall. There is no timeout and no preemption.
  - Only one channel requesting: it is re-granted after every section, with a 1-cycle bubble each time.
  - All channels requesting continuously: strict rotation 0,1,...,channels-1,0.
  - channels=1: round-robin degenerates to always granting channel 0; o_channel is always 0.
  - Reset asserted mid-FEED or mid-DRAIN: the partial section and any pending result are discarded; the block restarts from IDLE.
- Latency: the last sample of a section reaches o_valid after 2 cycles. A channel switch costs one idle cycle after the result handshake.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/FEED/DRAIN);
  - a channel-index width helper (max(1,$clog2(channels))).
- One sub-module: the existing section_min_max, instantiated once as the shared engine with width and sample_count passed through.
- Round-robin selection is a function or always block inside this module, not a separate module.

Test Plan:
- Reset, then channel 0 alone sends 1,9,3,5 (width=16, sample_count=4) -> o_valid with o_channel=0, min=1, max=9; i_ready[1]=0 throughout.
- Both channels valid; ch0 sends 10,20,30,40 and ch1 sends 7,7,2,8 -> first result ch0 min=10 max=40, then ch1 min=2 max=8; rotation returns to ch0 next.
- Back-pressure: hold o_ready=0 for 5 cycles after o_valid -> outputs stable, all i_ready=0, no samples lost; on o_ready=1 the result is accepted once.
- Ch0 granted, ch0 drops i_valid after 2 samples while ch1 is valid -> ch1 not granted until ch0 completes its 4 samples and the result is taken.
- Assert reset after 2 samples of a section -> no o_valid; after release, a new 4-sample section 100,0,50,25 gives min=0, max=100 (no contamination from the discarded section).
- channels=3, all valid, 6 sections -> o_channel sequence 0,1,2,0,1,2; exactly one IDLE cycle between each result handshake and the next grant.
